// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and sizing helper for the parametrised producer timer
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    // The next-value sum carries one extra bit so overshooting LIMIT near 2**WIDTH-1 is still visible
    function automatic int sum_width(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/timer_step.sv
// timer_step: combinational next-count computation with wrap/halt decision at LIMIT
module timer_step
    import timer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int LIMIT = 2**WIDTH-1,
    parameter int WRAP  = 1
)(
    input  logic [WIDTH-1:0] i_counter,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap,
    output logic             o_halt
);

    localparam int SW = sum_width(WIDTH);
    localparam logic [SW-1:0] C_STEP  = SW'(STEP);
    localparam logic [SW-1:0] C_LIMIT = SW'(LIMIT);

    logic [SW-1:0] w_sum;
    logic          w_over;

    assign w_sum  = {1'b0, i_counter} + C_STEP;
    assign w_over = w_sum > C_LIMIT;
    assign o_wrap = w_over && (WRAP != 0);
    assign o_halt = w_over && (WRAP == 0);
    assign o_next = !w_over ? w_sum[WIDTH-1:0] : (WRAP != 0 ? '0 : i_counter);

endmodule

// File: rtl/param_timer.sv
// param_timer: producer-side stepped sample timer with one-shot replay after pause, wrap/saturate and clear
module param_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int LIMIT = 2**WIDTH-1,
    parameter int WRAP  = 1
)(
    input  logic             clock_1,
    input  logic             reset,
    input  logic             t_en,
    input  logic             t_clear,
    output logic             t_valid,
    output logic [WIDTH-1:0] t_out,
    output logic             t_replay,
    output logic             t_wrap,
    output logic             t_done
);

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_cnt, w_cnt_n;
    logic [WIDTH-1:0] r_out, w_out_n;
    logic             r_valid, w_valid_n;
    logic             r_replay, w_replay_n;
    logic             r_wrap, w_wrap_n;
    logic             r_done, w_done_n;
    logic [WIDTH-1:0] w_step_next;
    logic             w_step_wrap;
    logic             w_step_halt;

    timer_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .LIMIT (LIMIT),
        .WRAP  (WRAP)
    ) u_step (
        .i_counter (r_cnt),
        .o_next    (w_step_next),
        .o_wrap    (w_step_wrap),
        .o_halt    (w_step_halt)
    );

    // Next state and next output values; valid/replay/wrap are pulses that default low each cycle
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_out_n    = r_out;
        w_valid_n  = 1'b0;
        w_replay_n = 1'b0;
        w_wrap_n   = 1'b0;
        w_done_n   = r_done;
        if (t_clear) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
            w_out_n   = '0;
            w_done_n  = 1'b0;
        end else if (r_state == HOLD) begin
            if (t_en) begin
                w_valid_n  = 1'b1;
                w_replay_n = 1'b1;
                w_state_n  = RUN;
            end
        end else if (r_state != DONE) begin
            if (t_en) begin
                w_out_n   = r_cnt;
                w_valid_n = 1'b1;
                w_cnt_n   = w_step_next;
                w_wrap_n  = w_step_wrap;
                w_done_n  = w_step_halt;
                w_state_n = w_step_halt ? DONE : RUN;
            end else begin
                w_state_n = (r_state == RUN) ? HOLD : IDLE;
            end
        end
    end

    // State, counter and output registers with asynchronous reset
    always_ff @(posedge clock_1 or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_replay <= 1'b0;
            r_wrap   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_out    <= w_out_n;
            r_valid  <= w_valid_n;
            r_replay <= w_replay_n;
            r_wrap   <= w_wrap_n;
            r_done   <= w_done_n;
        end
    end

    assign t_valid  = r_valid;
    assign t_out    = r_out;
    assign t_replay = r_replay;
    assign t_wrap   = r_wrap;
    assign t_done   = r_done;

endmodule
